fetch_byte_queue: RTL
=====================

# fetch_byte_queue

Instruction byte queue between the fetch unit and the decode stage. Accepts 16-byte fetch lines over a valid/ready handshake, holds up to two lines (32 bytes), and presents decode with a byte-aligned 16-byte window starting at the current instruction boundary. Decode returns the number of bytes it consumed each cycle, and the queue advances its byte offset and retires lines accordingly. A flush input discards all buffered bytes on a redirect and sets the entry offset for the first line that arrives afterwards.

## Interface
Parameters: none; widths are fixed at 16-byte lines.

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  fetch line valid
- in_ready  out  1  queue can accept a line this cycle
- in_data  in  128  fetch line; byte 0 = in_data[7:0] = lowest address
- out_bytes  out  128  aligned window; out_bytes[7:0] = byte at current offset
- out_count  out  5  number of valid bytes in the window, 0..16
- out_valid  out  1  out_count != 0
- consume_en  in  1  decode consumed bytes this cycle
- consume_len  in  5  bytes consumed, 1..16
- flush  in  1  discard all buffered bytes
- flush_offset  in  4  starting byte offset within the first line after a flush
- consume_err  out  1  sticky; set when consume_len > out_count

## Operation
- State:
  - head line, head_v
  - next line, next_v
  - offset[3:0]: byte position within the head line
  - err flag
- Window: byte k of out_bytes = byte (offset+k) of {next, head}. Bytes beyond the valid data read as 0.
- out_count:
  - 0 if !head_v
  - 16-offset if only head_v
  - 16 if both lines are valid, since 32-offset is capped at 16
- in_ready = !next_v; with FBQ_LOOKAHEAD_EN see Configuration.
- Accepted write (in_valid & in_ready):
  - Written to head if head is empty, or if head retires this cycle and next is empty.
  - Written to next otherwise.
- Consume (consume_en & consume_len ≤ out_count):
  - sum = offset + consume_len (5-bit, max 31).
  - sum < 16: offset = sum.
  - sum ≥ 16: head retires, next moves to head (head_v = next_v), next_v = 0, offset = sum-16.
- Illegal consume (consume_len > out_count, or consume_len == 0 with consume_en):
  - No state change.
  - consume_err set; it holds until reset or flush.
- Flush:
  - head_v = next_v = 0, offset = flush_offset, consume_err = 0.
  - Flush overrides consume and input in the same cycle; the input line is dropped even though in_ready was high.
- Reset:
  - head_v = next_v = 0, offset = 0, line registers = 0, consume_err = 0.
  - Therefore out_bytes = 0, out_count = 0, out_valid = 0, and in_ready = 1.

## Timing
- All state is registered. out_* and in_ready are combinational from state only (default build).
- Accepted line → visible in out_bytes and out_count on the next cycle.
- Consume takes effect on the next cycle; the window reflects the new offset one cycle after consume_en.
- Simultaneous accept and consume in the same cycle are both applied.
- Retire plus write with only head valid: the new line lands in head, and the offset wraps as computed.
- A flush asserted mid-stream takes effect at the next edge. Bytes presented in the flush cycle are still visible that cycle but must not be consumed.

## Configuration
- FBQ_LOOKAHEAD_EN defined:
  - in_ready = !next_v | (head retires this cycle & !flush), a combinational path from consume_en and consume_len.
  - The written line goes to next after the shift, allowing one line per cycle at full throughput.
- FBQ_LOOKAHEAD_EN undefined:
  - in_ready = !next_v only, with no input-to-ready combinational path.
  - Peak throughput drops to one line every two cycles when the queue is full.

## Test plan
- Reset, then push line L0 (bytes 0x00..0x0F) → next cycle out_count=16, out_bytes[7:0]=0x00; in_ready=1.
- Push L0 and L1 (0x10..0x1F), then consume 5 → out_bytes[7:0]=0x05, out_count=16. Consume 13 → head retires, offset=2, out_bytes[7:0]=0x12, out_count=14.
- Queue full, consume 3 → in_ready stays 0 without FBQ_LOOKAHEAD_EN. With the macro, in_ready goes high only in a cycle whose consume retires head.
- flush with flush_offset=9, then push L0 → out_count=7, out_bytes[7:0]=0x09, consume_err=0.
- Only head valid at offset 12 (out_count=4), consume 6 → consume_err=1, offset unchanged. The next flush clears consume_err.
- flush, in_valid and consume_en all high in one cycle → queue empty next cycle, offset=flush_offset, the input line is not stored.

Source files
------------

// File: rtl/fetch_byte_queue.sv
// fetch_byte_queue: two-line instruction byte queue between fetch and decode.
//
// Accepts 16-byte fetch lines over a valid/ready handshake and holds up to two
// of them (head, next). Decode sees a byte-aligned 16-byte window starting at
// the current offset into head, and reports how many bytes it consumed.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   in_valid        fetch line valid
//   in_ready        queue can accept a line this cycle
//   in_data         fetch line, byte 0 in bits [7:0]
//   out_bytes       aligned window, byte at current offset in bits [7:0]
//   out_count       valid bytes in the window (0..16)
//   out_valid       out_count != 0
//   consume_en      decode consumed bytes this cycle
//   consume_len     bytes consumed (1..16)
//   flush           discard all buffered bytes
//   flush_offset    entry offset within the first line after a flush
//   consume_err     sticky illegal-consume flag, cleared by reset or flush
//
// Build option FBQ_LOOKAHEAD_EN: in_ready also rises in a cycle whose consume
// retires head, so a full queue can take one line per cycle.
module fetch_byte_queue (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [127:0] out_bytes,
    output logic [4:0]   out_count,
    output logic         out_valid,
    input  logic         consume_en,
    input  logic [4:0]   consume_len,
    input  logic         flush,
    input  logic [3:0]   flush_offset,
    output logic         consume_err
);

    logic [127:0] head_q, head_d;
    logic [127:0] next_q, next_d;
    logic         head_v_q, head_v_d;
    logic         next_v_q, next_v_d;
    logic [3:0]   offset_q, offset_d;
    logic         err_q, err_d;

    logic [127:0] head_m, next_m;
    logic [7:0]   pair_bytes [32];
    logic         consume_ok;
    logic         consume_bad;
    logic [4:0]   sum;
    logic         retire;
    logic         accept;
    logic         hv_shift;

    // Invalid lines are masked so bytes beyond the valid data read as zero.
    assign head_m = head_v_q ? head_q : '0;
    assign next_m = next_v_q ? next_q : '0;

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            pair_bytes[i]      = head_m[8*i +: 8];
            pair_bytes[i + 16] = next_m[8*i +: 8];
        end
    end

    always_comb begin
        out_bytes = '0;
        for (int k = 0; k < 16; k++) begin
            out_bytes[8*k +: 8] = pair_bytes[5'({1'b0, offset_q}) + 5'(k)];
        end
    end

    always_comb begin
        if (!head_v_q) begin
            out_count = 5'd0;
        end else if (!next_v_q) begin
            out_count = 5'd16 - {1'b0, offset_q};
        end else begin
            out_count = 5'd16;
        end
    end

    assign out_valid   = (out_count != 5'd0);
    assign consume_err = err_q;

    assign consume_ok  = consume_en && (consume_len != 5'd0) && (consume_len <= out_count);
    assign consume_bad = consume_en && !consume_ok;
    assign sum         = {1'b0, offset_q} + consume_len;
    assign retire      = consume_ok && sum[4];

`ifdef FBQ_LOOKAHEAD_EN
    assign in_ready = !next_v_q || (retire && !flush);
`else
    assign in_ready = !next_v_q;
`endif

    assign accept   = in_valid && in_ready;
    // Head occupancy as seen after this cycle's retire shift.
    assign hv_shift = retire ? next_v_q : head_v_q;

    always_comb begin
        head_d   = head_q;
        next_d   = next_q;
        head_v_d = head_v_q;
        next_v_d = next_v_q;
        offset_d = offset_q;
        err_d    = err_q;

        if (flush) begin
            head_v_d = 1'b0;
            next_v_d = 1'b0;
            offset_d = flush_offset;
            err_d    = 1'b0;
        end else begin
            if (consume_bad) begin
                err_d = 1'b1;
            end else if (consume_ok) begin
                offset_d = sum[3:0];
                if (retire) begin
                    head_d   = next_q;
                    head_v_d = next_v_q;
                    next_v_d = 1'b0;
                end
            end

            if (accept) begin
                if (!hv_shift) begin
                    head_d   = in_data;
                    head_v_d = 1'b1;
                end else begin
                    next_d   = in_data;
                    next_v_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q   <= '0;
            next_q   <= '0;
            head_v_q <= 1'b0;
            next_v_q <= 1'b0;
            offset_q <= 4'd0;
            err_q    <= 1'b0;
        end else begin
            head_q   <= head_d;
            next_q   <= next_d;
            head_v_q <= head_v_d;
            next_v_q <= next_v_d;
            offset_q <= offset_d;
            err_q    <= err_d;
        end
    end

endmodule
